// File: rtl/param_stack_if.sv
// Bus bundle for param_stack: operation strobes, data, peek port and status.
interface param_stack_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 1024
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              clr;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_out;
    logic [CNT_W-1:0]  peek_off;
    logic [DATA_W-1:0] peek_out;
    logic              peek_valid;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              ovf;
    logic              udf;

    // Requester side: issues operations and peek offsets, observes the stack
    modport master (
        output clr, push, pop, d_in, peek_off,
        input  d_out, peek_out, peek_valid, count, empty, full, ovf, udf
    );

    // Stack side
    modport slave (
        input  clr, push, pop, d_in, peek_off,
        output d_out, peek_out, peek_valid, count, empty, full, ovf, udf
    );
endinterface

// File: rtl/param_stack.sv
// Parametrised synchronous LIFO with status, sticky error flags,
// same-cycle replace-top and an indexed combinational peek port.
module param_stack #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    param_stack_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    // Storage is deliberately not reset; entries at or above count are gated off
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              r_udf;

    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_ovf_nxt;
    logic              w_udf_nxt;
    logic              w_wr_en;
    logic [AW-1:0]     w_wr_idx;
    logic              w_full;
    logic              w_empty;
    logic              w_peek_valid;
    logic [AW-1:0]     w_top_idx;
    logic [AW-1:0]     w_peek_idx;

    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);

    // Next-state decode: clr dominates, then push/pop combinations
    always_comb begin
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        w_udf_nxt   = r_udf;
        w_wr_en     = 1'b0;
        w_wr_idx    = AW'(r_count);
        if (bus.clr) begin
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
            w_udf_nxt   = 1'b0;
        end else begin
            case ({bus.push, bus.pop})
                2'b10: begin
                    if (w_full) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_wr_en     = 1'b1;
                        w_wr_idx    = AW'(r_count);
                        w_count_nxt = r_count + C_ONE;
                    end
                end
                2'b01: begin
                    if (w_empty) begin
                        w_udf_nxt = 1'b1;
                    end else begin
                        w_count_nxt = r_count - C_ONE;
                    end
                end
                2'b11: begin
                    // Replace the top entry; on an empty stack this degenerates to a push
                    w_wr_en = 1'b1;
                    if (w_empty) begin
                        w_wr_idx    = '0;
                        w_count_nxt = C_ONE;
                    end else begin
                        w_wr_idx    = AW'(r_count - C_ONE);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Occupancy and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
            r_udf   <= w_udf_nxt;
        end
    end

    // Entry storage write port; held off while reset is asserted
    always_ff @(posedge clk) begin
        if (w_wr_en && rst_n) begin
            r_mem[w_wr_idx] <= bus.d_in;
        end
    end

    // Read-side index arithmetic: top = count-1, peek = count-1-peek_off
    assign w_peek_valid = (bus.peek_off < r_count);
    assign w_top_idx    = AW'(r_count - C_ONE);
    assign w_peek_idx   = AW'(r_count - C_ONE - bus.peek_off);

    assign bus.d_out      = w_empty      ? '0 : r_mem[w_top_idx];
    assign bus.peek_out   = w_peek_valid ? r_mem[w_peek_idx] : '0;
    assign bus.peek_valid = w_peek_valid;
    assign bus.count      = r_count;
    assign bus.empty      = w_empty;
    assign bus.full       = w_full;
    assign bus.ovf        = r_ovf;
    assign bus.udf        = r_udf;
endmodule
